sha256_msg_feeder: RTL
======================

Name: sha256_msg_feeder

Overview:
- Responder side of the message-word request/valid stream used by the SHA-256 core controller, on the wrapper side.
- Host (NIOS II) writes a 16-word message block over an Avalon-MM slave, then writes the start bit. The feeder pulses start to the core and streams buffered words in order while the core holds its request.
- On the core's done pulse it captures the 256-bit digest and a sticky done flag; the host reads both back.

Parameters:
- NUM_WORDS, 16, words per message block; sets buffer depth and pointer width (4 bits at default).
- DATA_W, 32, message word / bus data width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- avs_address  in  5  word address: 0-15 msg buffer, 16 control, 17 status, 24-31 hash
- avs_write  in  1  host write strobe
- avs_writedata  in  32  host write data
- avs_read  in  1  host read strobe
- avs_readdata  out  32  read data, registered, valid 1 cycle after avs_read
- core_start  out  1  one-cycle start pulse to the core controller
- data_request  in  1  core holds high while it wants words
- data_out  out  32  current message word
- data_valid  out  1  data_out holds a word this cycle
- done_in  in  1  one-cycle completion pulse from the core
- hash_in  in  256  final digest; H0 occupies bits [255:224]
- irq  out  1  level interrupt = done flag AND irq_en

Behaviour:
- Reset values: avs_readdata=0, core_start=0, data_out=0, data_valid=0, irq=0.
- Reset clears: word pointer=0, busy=0, done flag=0, irq_en=0, hash regs=0, state IDLE. Message buffer contents are not reset.
- States:
  - IDLE: on control write with bit0=1, pulse core_start for exactly 1 cycle, set busy, clear done flag, pointer=0, go to STREAM.
  - STREAM: each cycle data_request is sampled high and pointer<NUM_WORDS, next cycle drives data_out=buf[pointer], data_valid=1, and increments pointer.
    - data_request low: data_valid=0 next cycle and pointer holds; stream resumes at the same index when request returns.
    - After word NUM_WORDS-1 has been sent, go to WAIT. data_valid stays 0 even if request remains high.
  - WAIT: on done_in, latch hash_in into hash regs, set done flag, clear busy, go to IDLE.
- done_in in STREAM (early abort): same capture as WAIT, go to IDLE, pointer=0. done_in in IDLE is ignored.
- Stream latency: 1 cycle from request sampled high to first data_valid. Max throughput is 1 word/cycle, so 16 words take 16 consecutive valid cycles.
- Host interface:
  - Msg buffer writes are accepted only in IDLE; they are silently dropped otherwise.
  - Control register bit0 = start (self-clearing, reads 0); bit1 = irq_en (read/write).
  - Start written while busy is ignored.
- Status (addr 17): bit0 busy, bit1 done flag, bits[6:2] pointer. Any status read clears the done flag.
  - If done_in and a status read occur in the same cycle, the read returns the old value and the flag ends set.
- Hash readback: addr 24+k returns hash[255-32k -: 32], so H0 is at addr 24.
- Unmapped addresses read 0; writes to them are ignored.
- Msg buffer addresses read back the stored word in any state.
- Reset asserted mid-stream: data_valid and core_start drop immediately (asynchronous), return to IDLE; no partial state survives except buffer contents.

Test Plan:
- Write words 0x00000000..0x0000000F to addr 0-15, write 0x1 to addr 16, hold data_request high -> core_start pulses 1 cycle; data_valid high for 16 consecutive cycles beginning 1 cycle after request; data_out = 0x0..0xF in order; then data_valid=0.
- Toggle data_request low for 3 cycles after the 5th word -> data_valid=0 for those cycles; next word is 0x5; total words = 16, with no duplicates or skips.
- After the stream, pulse done_in with hash_in = {0x6a09e667, ..., 0x5be0cd19} -> status reads 0x2; addr 24 reads 0x6a09e667 and addr 31 reads 0x5be0cd19; next status read returns 0x0.
- Write 0xDEADBEEF to addr 3 and 0x1 to addr 16 while busy -> buffer word 3 unchanged; no second core_start pulse.
- Assert reset_n low after the 7th word, then release -> data_valid=0, status=0; a new start streams from word 0.
- Set irq_en (write 0x2), run a block to done_in -> irq=1 until status is read, then irq=0.

Source files
------------

// File: rtl/sha256_msg_feeder.sv
// Avalon-MM wrapper that buffers one SHA-256 message block, streams it to the
// core on request, and captures the final digest for host readback.
module sha256_msg_feeder #(
  parameter int NUM_WORDS = 16,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              core_start,
  input  logic              data_request,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              done_in,
  input  logic [255:0]      hash_in,
  output logic              irq
);

  localparam int PTR_W = $clog2(NUM_WORDS);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] WORD_CNT    = CNT_W'(NUM_WORDS);
  localparam logic [4:0]       ADDR_WORDS  = 5'(NUM_WORDS);
  localparam logic [4:0]       ADDR_CTRL   = 5'd16;
  localparam logic [4:0]       ADDR_STATUS = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        ptr_r;
  logic                    busy_r;
  logic                    done_flag_r;
  logic                    irq_en_r;
  logic [7:0][31:0]        hash_r;
  logic [DATA_W-1:0]       msg_buf_r [NUM_WORDS];

  logic                    buf_wr_s;
  logic                    ctrl_wr_s;
  logic                    stat_rd_s;
  logic [DATA_W-1:0]       stat_s;
  logic [DATA_W-1:0]       rd_data_s;

  // Register access decode.
  always_comb begin
    buf_wr_s  = avs_write && (avs_address < ADDR_WORDS) && (state_r == ST_IDLE);
    ctrl_wr_s = avs_write && (avs_address == ADDR_CTRL);
    stat_rd_s = avs_read && (avs_address == ADDR_STATUS);
  end

  // Status word: busy, done, pointer.
  always_comb begin
    stat_s            = {DATA_W{1'b0}};
    stat_s[0]         = busy_r;
    stat_s[1]         = done_flag_r;
    stat_s[2 +: CNT_W] = ptr_r;
  end

  // Read-data mux; hash word k maps H0 (bits 255:224) to the lowest address.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    if (avs_address < ADDR_WORDS) begin
      rd_data_s = msg_buf_r[avs_address[PTR_W-1:0]];
    end else if (avs_address == ADDR_CTRL) begin
      rd_data_s[1] = irq_en_r;
    end else if (avs_address == ADDR_STATUS) begin
      rd_data_s = stat_s;
    end else if (avs_address[4:3] == 2'b11) begin
      rd_data_s = DATA_W'(hash_r[3'd7 - avs_address[2:0]]);
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  // Message buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (buf_wr_s) begin
      msg_buf_r[avs_address[PTR_W-1:0]] <= avs_writedata;
    end
  end

  // Control FSM, stream outputs, digest capture and host readback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      ptr_r        <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      done_flag_r  <= 1'b0;
      irq_en_r     <= 1'b0;
      hash_r       <= {256{1'b0}};
      avs_readdata <= {DATA_W{1'b0}};
      core_start   <= 1'b0;
      data_out     <= {DATA_W{1'b0}};
      data_valid   <= 1'b0;
      irq          <= 1'b0;
    end else begin
      core_start <= 1'b0;
      data_valid <= 1'b0;
      irq        <= done_flag_r & irq_en_r;

      if (avs_read) begin
        avs_readdata <= rd_data_s;
      end
      if (ctrl_wr_s) begin
        irq_en_r <= avs_writedata[1];
      end
      // A same-cycle done capture below overrides this clear.
      if (stat_rd_s) begin
        done_flag_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (ctrl_wr_s && avs_writedata[0]) begin
            core_start  <= 1'b1;
            busy_r      <= 1'b1;
            done_flag_r <= 1'b0;
            ptr_r       <= {CNT_W{1'b0}};
            state_r     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (done_in) begin
            hash_r      <= hash_in;
            done_flag_r <= 1'b1;
            busy_r      <= 1'b0;
            ptr_r       <= {CNT_W{1'b0}};
            state_r     <= ST_IDLE;
          end else if (data_request && (ptr_r < WORD_CNT)) begin
            data_out   <= msg_buf_r[ptr_r[PTR_W-1:0]];
            data_valid <= 1'b1;
            ptr_r      <= ptr_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (ptr_r == LAST_IDX) begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (done_in) begin
            hash_r      <= hash_in;
            done_flag_r <= 1'b1;
            busy_r      <= 1'b0;
            ptr_r       <= {CNT_W{1'b0}};
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
